// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the program controller and its instruction decoder:
// register codes used in the dst/src instruction fields, data-bus source
// select codes, reg_en bit positions, opcode field values and the sequencer
// FSM state enum.
// -----------------------------------------------------------------------------
package cu_pkg;

  // Register codes as they appear in the 3-bit dst/src instruction fields.
  localparam logic [2:0] REG_R  = 3'd4;
  localparam logic [2:0] REG_I  = 3'd6;
  localparam logic [2:0] REG_DM = 3'd7;

  // Data-bus source select codes beyond the eight register sources (0-7).
  localparam logic [3:0] SRC_NONE   = 4'd0;
  localparam logic [3:0] SRC_NIBBLE = 4'd8;
  localparam logic [3:0] SRC_PINS   = 4'd9;

  // reg_en bit positions. Bits 0-7 line up with the register codes, except
  // that a destination code of 4 (r) on the bus drives the output register.
  localparam int REG_EN_W = 10;
  localparam int EN_R     = 4;
  localparam int EN_I     = 6;
  localparam int EN_O     = 8;

  // Opcode field values.
  localparam logic [1:0] OP_MOVE  = 2'b10;   // ir[7:6]
  localparam logic [2:0] OP_ALU   = 3'b110;  // ir[7:5]
  localparam logic [3:0] OP_JUMP  = 4'b1110; // ir[7:4]
  localparam logic [3:0] OP_CJUMP = 4'b1111; // ir[7:4]

  // Word placed in ir when the pipeline injects a bubble.
  localparam logic [7:0] NOP_WORD = 8'h00;

  typedef enum logic [1:0] {
    ST_RST,
    ST_FILL,
    ST_RUN
  } pc_state_t;

  // One-hot write enable for a bus destination register code.
  function automatic logic [REG_EN_W-1:0] dst_enable(input logic [2:0] dst);
    logic [REG_EN_W-1:0] en;
    en = '0;
    if (dst == REG_R) begin
      en[EN_O] = 1'b1;
    end else begin
      en[dst] = 1'b1;
    end
    return en;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// -----------------------------------------------------------------------------
// instruction_decoder
// Purely combinational decode of the execute-stage instruction.
//   ir          in   8   instruction being executed
//   zero_flag   in   1   computational-unit r == 0 (for conditional jumps)
//   source_sel  out  4   data-bus source select
//   reg_en      out 10   register / output write enables
//   i_sel       out  1   i post-increment (i += m) select
//   x_sel       out  1   ALU x operand select (x1 when set)
//   y_sel       out  1   ALU y operand select (y1 when set)
//   jump_taken  out  1   this instruction redirects the fetch address
// The caller is responsible for masking the outputs while ir holds a bubble.
// -----------------------------------------------------------------------------
module instruction_decoder
  import cu_pkg::*;
(
  input  logic [7:0]          ir,
  input  logic                zero_flag,
  output logic [3:0]          source_sel,
  output logic [REG_EN_W-1:0] reg_en,
  output logic                i_sel,
  output logic                x_sel,
  output logic                y_sel,
  output logic                jump_taken
);

  logic       is_bus;
  logic [2:0] dst;
  logic       src_is_dm;

  always_comb begin
    source_sel = SRC_NONE;
    reg_en     = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    jump_taken = 1'b0;
    is_bus     = 1'b0;
    dst        = 3'd0;
    src_is_dm  = 1'b0;

    if (ir[7] == 1'b0) begin
      // Load immediate: nibble goes onto the bus.
      is_bus     = 1'b1;
      dst        = ir[6:4];
      source_sel = SRC_NIBBLE;
    end else if (ir[7:6] == OP_MOVE) begin
      is_bus    = 1'b1;
      dst       = ir[5:3];
      src_is_dm = (ir[2:0] == REG_DM);
      // r -> r is meaningless as a move, so that code reads the input pins.
      if ((ir[2:0] == REG_R) && (ir[5:3] == REG_R)) begin
        source_sel = SRC_PINS;
      end else begin
        source_sel = {1'b0, ir[2:0]};
      end
    end else if (ir[7:5] == OP_ALU) begin
      x_sel = ir[4];
      y_sel = ir[3];
      // Codes 000 and 111 with ir[3] set are ALU no-ops: r is left alone.
      reg_en[EN_R] = !(ir[3] && ((ir[2:0] == 3'b000) || (ir[2:0] == 3'b111)));
    end else if (ir[7:4] == OP_JUMP) begin
      jump_taken = 1'b1;
    end else begin
      // OP_CJUMP: taken only while the last ALU result was non-zero.
      jump_taken = !zero_flag;
    end

    if (is_bus) begin
      reg_en = dst_enable(dst);
      // Any data-memory access post-increments i, unless i itself is the
      // destination (the bus write wins in that case).
      if ((src_is_dm || (dst == REG_DM)) && (dst != REG_I)) begin
        reg_en[EN_I] = 1'b1;
        i_sel        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_controller.sv
// -----------------------------------------------------------------------------
// program_controller
// Two-stage fetch/execute sequencer for a 4-bit nibble processor.
// Fetch latches pm_data into ir and advances pm_addr; execute decodes ir.
// A taken jump loads {page of the jump, ir[3:0]} into pm_addr and replaces
// the word fetched in that cycle with a bubble.
//   RESET_VECTOR  param      first fetch address after reset
//   clk           in    1    clock
//   sync_reset    in    1    asynchronous, active-high reset (despite name)
//   pm_data       in    8    program memory word at pm_addr
//   zero_flag     in    1    computational-unit r == 0
//   hold          in    1    pipeline freeze (only with SEQ_HOLD_EN defined)
//   pm_addr       out   8    program counter / fetch address
//   ir            out   8    execute-stage instruction
//   nibble_ir     out   4    ir[3:0]
//   source_sel    out   4    data-bus source select
//   reg_en        out  10    register write enables
//   i_sel/x_sel/y_sel out 1  i increment / ALU operand selects
//   bubble        out   1    ir holds an injected NOP
// Build option: define SEQ_HOLD_EN to add the hold port.
// -----------------------------------------------------------------------------
module program_controller
  import cu_pkg::*;
#(
  parameter logic [7:0] RESET_VECTOR = 8'h00
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic [7:0]          pm_data,
  input  logic                zero_flag,
`ifdef SEQ_HOLD_EN
  input  logic                hold,
`endif
  output logic [7:0]          pm_addr,
  output logic [7:0]          ir,
  output logic [3:0]          nibble_ir,
  output logic [3:0]          source_sel,
  output logic [REG_EN_W-1:0] reg_en,
  output logic                i_sel,
  output logic                x_sel,
  output logic                y_sel,
  output logic                bubble
);

  pc_state_t  state_reg, state_next;
  logic [7:0] pm_addr_reg, pm_addr_next;
  logic [7:0] ir_reg, ir_next;
  logic       inj_reg, inj_next;   // ir holds a jump-flush bubble

  logic       freeze;
  logic       executing;
  logic [7:0] ir_addr;

  logic [3:0]          dec_source_sel;
  logic [REG_EN_W-1:0] dec_reg_en;
  logic                dec_i_sel;
  logic                dec_x_sel;
  logic                dec_y_sel;
  logic                dec_jump_taken;

`ifdef SEQ_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  // The instruction in ir was fetched from the address just before the
  // current fetch address; its page forms the jump target's high nibble.
  assign ir_addr   = pm_addr_reg - 8'd1;
  assign executing = (state_reg == ST_RUN) && !inj_reg;

  instruction_decoder u_decoder (
    .ir         (ir_reg),
    .zero_flag  (zero_flag),
    .source_sel (dec_source_sel),
    .reg_en     (dec_reg_en),
    .i_sel      (dec_i_sel),
    .x_sel      (dec_x_sel),
    .y_sel      (dec_y_sel),
    .jump_taken (dec_jump_taken)
  );

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_reg   <= ST_RST;
      pm_addr_reg <= RESET_VECTOR;
      ir_reg      <= NOP_WORD;
      inj_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pm_addr_reg <= pm_addr_next;
      ir_reg      <= ir_next;
      inj_reg     <= inj_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pm_addr_next = pm_addr_reg;
    ir_next      = ir_reg;
    inj_next     = inj_reg;

    // While frozen everything holds, so a pending jump simply stays decoded
    // and redirects on the first unfrozen edge.
    if (!freeze) begin
      case (state_reg)
        ST_RST: begin
          state_next = ST_FILL;
        end
        ST_FILL: begin
          state_next   = ST_RUN;
          ir_next      = pm_data;
          pm_addr_next = pm_addr_reg + 8'd1;
          inj_next     = 1'b0;
        end
        default: begin
          if (executing && dec_jump_taken) begin
            pm_addr_next = {ir_addr[7:4], ir_reg[3:0]};
            ir_next      = NOP_WORD;
            inj_next     = 1'b1;
          end else begin
            ir_next      = pm_data;
            pm_addr_next = pm_addr_reg + 8'd1;
            inj_next     = 1'b0;
          end
        end
      endcase
    end
  end

  assign pm_addr    = pm_addr_reg;
  assign ir         = ir_reg;
  assign nibble_ir  = ir_reg[3:0];
  assign bubble     = !executing;
  assign source_sel = executing ? dec_source_sel : SRC_NONE;
  assign reg_en     = (executing && !freeze) ? dec_reg_en : '0;
  assign i_sel      = executing && dec_i_sel;
  assign x_sel      = executing && dec_x_sel;
  assign y_sel      = executing && dec_y_sel;

endmodule

// File: tb/tb_program_controller.sv
// -----------------------------------------------------------------------------
// tb_program_controller
// Self-checking bench for program_controller. A behavioural model tracks the
// fetch address, the executing instruction and its address, and decodes
// instructions from the opcode ranges. Directed sequences cover reset
// release, the load/move examples, jumps and conditional jumps; a random
// phase then runs random program memory, flags, holds and resets.
// -----------------------------------------------------------------------------
module tb_program_controller;

`ifdef SEQ_HOLD_EN
  localparam bit HAS_HOLD = 1'b1;
`else
  localparam bit HAS_HOLD = 1'b0;
`endif

  logic       clk;
  logic       sync_reset;
  logic [7:0] pm_data;
  logic       zero_flag;
  logic       hold;
  logic [7:0] pm_addr;
  logic [7:0] ir;
  logic [3:0] nibble_ir;
  logic [3:0] source_sel;
  logic [9:0] reg_en;
  logic       i_sel;
  logic       x_sel;
  logic       y_sel;
  logic       bubble;

  logic [7:0] mem [256];

  int n_checks;
  int n_pass;
  int n_tick;

  // model state
  int         m_phase;     // edges since reset release, saturating at 2
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  logic [7:0] m_ir_addr;
  bit         m_nop;

  typedef struct packed {
    logic [3:0] src;
    logic [9:0] en;
    logic       isel;
    logic       xsel;
    logic       ysel;
    logic       taken;
  } exp_t;

  program_controller #(.RESET_VECTOR(8'h00)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .pm_data    (pm_data),
    .zero_flag  (zero_flag),
`ifdef SEQ_HOLD_EN
    .hold       (hold),
`endif
    .pm_addr    (pm_addr),
    .ir         (ir),
    .nibble_ir  (nibble_ir),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .bubble     (bubble)
  );

  assign pm_data = mem[pm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected decode from the instruction-set rules, by opcode range.
  function automatic exp_t ref_decode(input logic [7:0] ins, input logic zf);
    exp_t d;
    int   dst;
    int   src;
    int   low;
    bit   bus;
    int   en_bit [8];
    en_bit = '{0, 1, 2, 3, 8, 5, 6, 7};
    d   = '0;
    bus = 1'b0;
    dst = 0;
    src = -1;
    low = int'(ins[2:0]);
    if (ins < 8'h80) begin
      bus   = 1'b1;
      dst   = int'(ins[6:4]);
      d.src = 4'd8;
    end else if (ins < 8'hC0) begin
      bus   = 1'b1;
      dst   = int'(ins[5:3]);
      src   = low;
      d.src = (src == 4 && dst == 4) ? 4'd9 : 4'(src);
    end else if (ins < 8'hE0) begin
      d.xsel  = ins[4];
      d.ysel  = ins[3];
      d.en[4] = !(ins[3] && (low == 0 || low == 7));
    end else if (ins < 8'hF0) begin
      d.taken = 1'b1;
    end else begin
      d.taken = !zf;
    end
    if (bus) begin
      d.en[en_bit[dst]] = 1'b1;
      if ((src == 7 || dst == 7) && dst != 6) begin
        d.en[6] = 1'b1;
        d.isel  = 1'b1;
      end
    end
    return d;
  endfunction

  function automatic bit m_exec();
    return (m_phase == 2) && !m_nop;
  endfunction

  function automatic bit hold_eff();
    return HAS_HOLD && (hold == 1'b1);
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_pc      = 8'h00;
    m_ir      = 8'h00;
    m_ir_addr = 8'h00;
    m_nop     = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    exp_t d;
    d = ref_decode(m_ir, zero_flag);
    if (!m_exec()) d = '0;
    if (hold_eff()) d.en = '0;
    check({tag, ".pm_addr"},    32'(pm_addr),    32'(m_pc));
    check({tag, ".ir"},         32'(ir),         32'(m_ir));
    check({tag, ".nibble_ir"},  32'(nibble_ir),  32'(m_ir[3:0]));
    check({tag, ".bubble"},     32'(bubble),     32'(!m_exec()));
    check({tag, ".source_sel"}, 32'(source_sel), 32'(d.src));
    check({tag, ".reg_en"},     32'(reg_en),     32'(d.en));
    check({tag, ".i_sel"},      32'(i_sel),      32'(d.isel));
    check({tag, ".x_sel"},      32'(x_sel),      32'(d.xsel));
    check({tag, ".y_sel"},      32'(y_sel),      32'(d.ysel));
  endtask

  task automatic model_step();
    exp_t d;
    if (hold_eff()) return;
    d = ref_decode(m_ir, zero_flag);
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 || !(m_exec() && d.taken)) begin
      m_phase   = 2;
      m_ir      = mem[m_pc];
      m_ir_addr = m_pc;
      m_pc      = m_pc + 8'd1;
      m_nop     = 1'b0;
    end else begin
      m_pc  = {m_ir_addr[7:4], m_ir[3:0]};
      m_ir  = 8'h00;
      m_nop = 1'b1;
    end
  endtask

  // One clock: apply inputs, check the current cycle, advance model and DUT.
  task automatic tick(input logic zf, input logic hd);
    zero_flag = zf;
    hold      = hd;
    #1;
    $display("cyc %0d pm_addr=%02h ir=%02h bubble=%0d reg_en=%03h src=%0d zf=%0d hold=%0d",
             n_tick, pm_addr, ir, bubble, reg_en, source_sel, zf, hd);
    check_outputs("cyc");
    model_step();
    n_tick++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge.
  task automatic do_reset();
    sync_reset = 1'b1;
    #1;
    model_reset();
    $display("reset at %0t", $time);
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    sync_reset = 1'b0;
  endtask

  initial begin
    int   guard;
    logic [7:0] save_pc;
    logic [7:0] save_ir;

    n_checks   = 0;
    n_pass     = 0;
    n_tick     = 0;
    sync_reset = 1'b1;
    zero_flag  = 1'b0;
    hold       = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 8'hDF));
    mem[0]    = 8'h35;
    mem[1]    = 8'hBF;
    mem[2]    = 8'hA4;
    mem[8'h23] = 8'hC1;
    mem[8'h24] = 8'hF7;
    mem[8'h25] = 8'hE3;
    mem[8'h27] = 8'h35;
    model_reset();
    @(posedge clk);
    #1;

    // Reset release sequence and the load/move examples.
    do_reset();
    check("rel0.pm_addr", 32'(pm_addr), 32'h00);
    check("rel0.bubble",  32'(bubble),  32'd1);
    tick(1'b0, 1'b0);
    check("rel1.pm_addr", 32'(pm_addr), 32'h00);
    check("rel1.bubble",  32'(bubble),  32'd1);
    tick(1'b0, 1'b0);
    check("rel2.pm_addr", 32'(pm_addr), 32'h01);
    check("rel2.bubble",  32'(bubble),  32'd0);
    check("ld35.source_sel", 32'(source_sel), 32'd8);
    check("ld35.reg_en",     32'(reg_en),     32'h008);
    tick(1'b0, 1'b0);
    check("rel3.pm_addr",    32'(pm_addr),    32'h02);
    check("mvBF.source_sel", 32'(source_sel), 32'd7);
    check("mvBF.reg_en",     32'(reg_en),     32'h0C0);
    check("mvBF.i_sel",      32'(i_sel),      32'd1);
    tick(1'b0, 1'b0);
    check("mvA4.source_sel", 32'(source_sel), 32'd9);
    check("mvA4.reg_en",     32'(reg_en),     32'h100);

    // Walk to the conditional jump at 0x24 through jump-free filler.
    guard = 0;
    while (!(m_exec() && m_ir_addr == 8'h24) && guard < 100) begin
      tick(1'($urandom_range(0, 1)), 1'b0);
      guard++;
    end
    check("reach_F7", 32'(guard < 100), 32'd1);
    tick(1'b1, 1'b0);                     // ALU result was zero: not taken
    check("cj_nt.pm_addr", 32'(pm_addr), 32'h26);
    check("cj_nt.ir",      32'(ir),      32'hE3);
    tick(1'b0, 1'b0);                     // E3 at 0x25 jumps to 0x23
    check("jmp.pm_addr", 32'(pm_addr), 32'h23);
    check("jmp.bubble",  32'(bubble),  32'd1);
    check("jmp.reg_en",  32'(reg_en),  32'h000);
    tick(1'b0, 1'b0);
    check("alu.ir",     32'(ir),     32'hC1);
    check("alu.reg_en", 32'(reg_en), 32'h010);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);                     // ALU result non-zero: taken
    check("cj_t.pm_addr", 32'(pm_addr), 32'h27);
    check("cj_t.bubble",  32'(bubble),  32'd1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    if (HAS_HOLD) begin
      save_pc = m_pc;
      save_ir = m_ir;
      for (int h = 0; h < 3; h++) begin
        tick(1'b0, 1'b1);
        check("hold.pm_addr", 32'(pm_addr), 32'(save_pc));
        check("hold.ir",      32'(ir),      32'(save_ir));
        check("hold.reg_en",  32'(reg_en),  32'h000);
      end
      tick(1'b0, 1'b0);
      check("resume.pm_addr", 32'(pm_addr), 32'(save_pc + 8'd1));
    end

    // Random program memory, flags, holds and occasional resets.
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        tick(1'($urandom_range(0, 1)),
             1'(HAS_HOLD && ($urandom_range(0, 3) == 0)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
